// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side prediction, MEM-stage resolution and BTB write signals
// master drives pc, BTB read results and resolution info; slave is the predictor.
interface branch_predictor_if;
  logic [15:0] pc;
  logic        fetch_adv;
  logic        btb_hit;
  logic        btb_uc;
  logic [15:0] btb_target;
  logic        res_valid;
  logic        res_branch;
  logic        res_uc;
  logic        res_taken;
  logic [15:0] res_target;
  logic [3:0]  index_fetch;
  logic [11:0] tag_fetch;
  logic [15:0] next_pc;
  logic        full;
  logic        flush;
  logic        btb_write;
  logic [3:0]  index_mem;
  logic [11:0] tag_mem;
  logic [15:0] btb_wtarget;
  logic        btb_wuc;
  modport master(
    output pc, fetch_adv, btb_hit, btb_uc, btb_target,
    output res_valid, res_branch, res_uc, res_taken, res_target,
    input  index_fetch, tag_fetch, next_pc, full, flush,
    input  btb_write, index_mem, tag_mem, btb_wtarget, btb_wuc
  );
  modport slave(
    input  pc, fetch_adv, btb_hit, btb_uc, btb_target,
    input  res_valid, res_branch, res_uc, res_taken, res_target,
    output index_fetch, tag_fetch, next_pc, full, flush,
    output btb_write, index_mem, tag_mem, btb_wtarget, btb_wuc
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: next-PC selection from BTB + 2-bit counters, in-order resolve queue, flush and BTB write
// Ports: clk, reset (sync, active-high); bp (slave) carries fetch pc/BTB read result in,
// MEM-stage resolution in, and next_pc/full/flush/BTB read+write port out.
module branch_predictor #(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  branch_predictor_if.slave bp
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [15:0]   qpc_q [DEPTH];
  logic [15:0]   qpc_d [DEPTH];
  logic [15:0]   qtgt_q [DEPTH];
  logic [15:0]   qtgt_d [DEPTH];
  logic [1:0]    ctr_q [16];
  logic [1:0]    ctr_d [16];
  logic          pred_taken, resolve, enq, upd;
  logic [15:0]   pred_tgt, head_pc, actual_next;
  logic [3:0]    hidx;
  assign pred_taken  = bp.btb_hit & (bp.btb_uc | ctr_q[bp.pc[3:0]][1]);
  assign pred_tgt    = pred_taken ? bp.btb_target : bp.pc + 16'd2;
  assign head_pc     = qpc_q[rd_q];
  assign hidx        = head_pc[3:0];
  assign resolve     = bp.res_valid & (count_q != '0);
  assign actual_next = (bp.res_branch & bp.res_taken) ? bp.res_target : head_pc + 16'd2;
  // Comparing full next-PC catches wrong direction, wrong target and stale BTB hits alike.
  assign bp.flush    = resolve & (actual_next != qtgt_q[rd_q]);
  assign bp.full     = count_q == (AW+1)'(DEPTH);
  assign enq         = bp.fetch_adv & ~bp.full & ~bp.flush;
  assign upd         = resolve & bp.res_branch & ~bp.res_uc;
  assign bp.next_pc     = bp.flush ? actual_next : pred_tgt;
  assign bp.index_fetch = bp.pc[3:0];
  assign bp.tag_fetch   = bp.pc[15:4];
  assign bp.btb_write   = resolve & bp.res_branch & bp.res_taken;
  assign bp.index_mem   = hidx;
  assign bp.tag_mem     = head_pc[15:4];
  assign bp.btb_wtarget = bp.res_target;
  assign bp.btb_wuc     = bp.res_uc;
  always_comb begin
    qpc_d  = qpc_q;
    qtgt_d = qtgt_q;
    ctr_d  = ctr_q;
    if (enq) begin
      qpc_d[wr_q]  = bp.pc;
      qtgt_d[wr_q] = pred_tgt;
    end
    if (upd)
      ctr_d[hidx] = bp.res_taken ? ((ctr_q[hidx] == 2'b11) ? 2'b11 : ctr_q[hidx] + 2'b01)
                                 : ((ctr_q[hidx] == 2'b00) ? 2'b00 : ctr_q[hidx] - 2'b01);
    count_d = bp.flush ? '0 : count_q + (AW+1)'(enq) - (AW+1)'(resolve);
    rd_d    = bp.flush ? '0 : rd_q + AW'(resolve);
    wr_d    = bp.flush ? '0 : wr_q + AW'(enq);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      ctr_q   <= '{default: 2'b01};
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ctr_q   <= ctr_d;
    end
  end
  // Entry payload needs no reset: it is only read while count_q says it is valid.
  always_ff @(posedge clk) begin
    qpc_q  <= qpc_d;
    qtgt_q <= qtgt_d;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios plus randomized run against a queue/array reference model
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  branch_predictor_if bi();
  branch_predictor #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bp(bi.slave));
  typedef struct {logic [15:0] pc; logic [15:0] tgt;} ent_t;
  ent_t mq[$];
  int mctr[16];
  logic [15:0] e_next, e_ptgt;
  logic e_full, e_flush, e_bw, e_res;
  task automatic model_eval();
    logic pt;
    logic [15:0] an;
    pt = bi.btb_hit && (bi.btb_uc || mctr[bi.pc[3:0]] >= 2);
    e_ptgt = pt ? bi.btb_target : bi.pc + 16'd2;
    e_full = (mq.size() == 4);
    e_res = bi.res_valid && (mq.size() > 0);
    e_flush = 1'b0;
    e_bw = 1'b0;
    e_next = e_ptgt;
    if (e_res) begin
      an = (bi.res_branch && bi.res_taken) ? bi.res_target : mq[0].pc + 16'd2;
      e_flush = (an != mq[0].tgt);
      e_bw = bi.res_branch && bi.res_taken;
      if (e_flush) e_next = an;
    end
  endtask
  task automatic model_commit();
    int i;
    ent_t e;
    if (reset) begin
      mq.delete();
      foreach (mctr[k]) mctr[k] = 1;
      return;
    end
    if (e_res) begin
      i = mq[0].pc[3:0];
      if (bi.res_branch && !bi.res_uc) mctr[i] = bi.res_taken ? ((mctr[i] < 3) ? mctr[i] + 1 : 3)
                                                              : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
      void'(mq.pop_front());
    end
    if (e_flush) mq.delete();
    else if (bi.fetch_adv && !e_full) begin
      e.pc = bi.pc;
      e.tgt = e_ptgt;
      mq.push_back(e);
    end
  endtask
  task automatic cycle();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask
  task automatic idle();
    bi.fetch_adv = 0; bi.btb_hit = 0; bi.btb_uc = 0; bi.btb_target = 16'h0;
    bi.res_valid = 0; bi.res_branch = 0; bi.res_uc = 0; bi.res_taken = 0; bi.res_target = 16'h0;
  endtask
  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask
  task automatic fetch(input logic [15:0] p, input logic hit, input logic uc, input logic [15:0] tgt);
    idle();
    bi.pc = p; bi.btb_hit = hit; bi.btb_uc = uc; bi.btb_target = tgt; bi.fetch_adv = 1;
    cycle();
    idle();
  endtask
  task automatic set_res(input logic br, input logic uc, input logic tk, input logic [15:0] tgt);
    idle();
    bi.res_valid = 1; bi.res_branch = br; bi.res_uc = uc; bi.res_taken = tk; bi.res_target = tgt;
    #1;
  endtask
  task automatic test_reset();
    bi.pc = 16'h3000;
    do_reset();
    bi.fetch_adv = 1;
    #1;
    checks++; if (bi.full !== 1'b0 || bi.flush !== 1'b0 || bi.btb_write !== 1'b0) begin errors++; $display("FAIL reset_outs full=%b flush=%b bw=%b expected 0 0 0", bi.full, bi.flush, bi.btb_write); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bi.next_pc !== 16'h3002) begin errors++; $display("FAIL fill_next_pc got %h expected 3002", bi.next_pc); end
      checks++; if (bi.full !== (i == 4)) begin errors++; $display("FAIL fill_full i=%0d got %b expected %b", i, bi.full, i == 4); end
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      set_res(0, 0, 0, 16'h0);
      checks++; if (bi.flush !== 1'b0) begin errors++; $display("FAIL drain_flush i=%0d got %b expected 0", i, bi.flush); end
      cycle();
    end
    set_res(1, 0, 1, 16'h5000);
    checks++; if (bi.flush !== 1'b0 || bi.btb_write !== 1'b0) begin errors++; $display("FAIL dropped_fifth flush=%b bw=%b expected 0 0", bi.flush, bi.btb_write); end
    cycle();
  endtask
  task automatic test_taken_miss();
    do_reset();
    fetch(16'h3004, 0, 0, 16'h0);
    set_res(1, 0, 1, 16'h3020);
    checks++; if (bi.flush !== 1'b1 || bi.next_pc !== 16'h3020) begin errors++; $display("FAIL miss_flush flush=%b next=%h expected 1 3020", bi.flush, bi.next_pc); end
    checks++; if (bi.btb_write !== 1'b1 || bi.index_mem !== 4'h4 || bi.tag_mem !== 12'h300 || bi.btb_wtarget !== 16'h3020) begin errors++; $display("FAIL miss_btbw bw=%b idx=%h tag=%h tgt=%h expected 1 4 300 3020", bi.btb_write, bi.index_mem, bi.tag_mem, bi.btb_wtarget); end
    cycle();
    set_res(1, 0, 1, 16'h3020);
    checks++; if (bi.flush !== 1'b0 || bi.btb_write !== 1'b0) begin errors++; $display("FAIL empty_resolve flush=%b bw=%b expected 0 0", bi.flush, bi.btb_write); end
    cycle();
    idle();
    bi.pc = 16'h3004; bi.btb_hit = 1; bi.btb_target = 16'h3020;
    #1;
    checks++; if (bi.next_pc !== 16'h3020) begin errors++; $display("FAIL ctr10_predict got %h expected 3020", bi.next_pc); end
  endtask
  task automatic test_not_taken();
    fetch(16'h3004, 1, 0, 16'h3020);
    set_res(1, 0, 0, 16'h3020);
    checks++; if (bi.flush !== 1'b1 || bi.next_pc !== 16'h3006 || bi.btb_write !== 1'b0) begin errors++; $display("FAIL nt_flush flush=%b next=%h bw=%b expected 1 3006 0", bi.flush, bi.next_pc, bi.btb_write); end
    cycle();
    bi.pc = 16'h3004; bi.btb_hit = 1; bi.btb_target = 16'h3020;
    #1;
    checks++; if (bi.next_pc !== 16'h3006) begin errors++; $display("FAIL ctr01_predict got %h expected 3006", bi.next_pc); end
  endtask
  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(16'h3004, 1, 0, 16'h3020);
      set_res(1, 0, 1, 16'h3020);
      if (i > 0) begin
        checks++; if (bi.flush !== 1'b0) begin errors++; $display("FAIL sat_taken i=%0d flush got %b expected 0", i, bi.flush); end
      end
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      fetch(16'h3004, 1, 0, 16'h3020);
      set_res(1, 0, 0, 16'h3020);
      cycle();
    end
    bi.pc = 16'h3004; bi.btb_hit = 1; bi.btb_target = 16'h3020;
    #1;
    checks++; if (bi.next_pc !== 16'h3006) begin errors++; $display("FAIL sat_then_dec got %h expected 3006", bi.next_pc); end
  endtask
  task automatic test_uncond();
    do_reset();
    bi.pc = 16'h3008; bi.btb_hit = 1; bi.btb_uc = 1; bi.btb_target = 16'h4000; bi.fetch_adv = 1;
    #1;
    checks++; if (bi.next_pc !== 16'h4000) begin errors++; $display("FAIL uc_predict got %h expected 4000", bi.next_pc); end
    cycle();
    set_res(1, 1, 1, 16'h4100);
    checks++; if (bi.flush !== 1'b1 || bi.next_pc !== 16'h4100 || bi.btb_write !== 1'b1 || bi.btb_wuc !== 1'b1) begin errors++; $display("FAIL uc_resolve flush=%b next=%h bw=%b wuc=%b expected 1 4100 1 1", bi.flush, bi.next_pc, bi.btb_write, bi.btb_wuc); end
    cycle();
    bi.pc = 16'h3008; bi.btb_hit = 1; bi.btb_target = 16'h4000;
    #1;
    checks++; if (bi.next_pc !== 16'h300a) begin errors++; $display("FAIL uc_ctr_unchanged got %h expected 300a", bi.next_pc); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) fetch(16'h3100 + 16'(2 * i), 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      idle();
      bi.pc = 16'h3200 + 16'(2 * i); bi.fetch_adv = 1; bi.res_valid = 1;
      #1;
      checks++; if (bi.full !== 1'b0 || bi.flush !== 1'b0) begin errors++; $display("FAIL b2b i=%0d full=%b flush=%b expected 0 0", i, bi.full, bi.flush); end
      cycle();
    end
    fetch(16'h3300, 0, 0, 16'h0);
    #1;
    checks++; if (bi.full !== 1'b1) begin errors++; $display("FAIL b2b_count full got %b expected 1", bi.full); end
  endtask
  task automatic test_random();
    logic [15:0] tg[4];
    tg[0] = 16'h3020; tg[1] = 16'h4000; tg[2] = 16'h3006; tg[3] = 16'h0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 80) == 0);
      bi.pc = {($urandom_range(0, 3) != 0) ? 12'h300 : 12'($urandom), 4'($urandom)};
      bi.fetch_adv = 1'($urandom);
      bi.btb_hit = 1'($urandom);
      bi.btb_uc = ($urandom_range(0, 3) == 0);
      tg[3] = 16'($urandom);
      bi.btb_target = tg[$urandom_range(0, 3)];
      bi.res_valid = ($urandom_range(0, 2) != 0);
      bi.res_branch = 1'($urandom);
      bi.res_uc = ($urandom_range(0, 3) == 0);
      bi.res_taken = 1'($urandom);
      bi.res_target = tg[$urandom_range(0, 3)];
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
        bi.res_branch = 1; bi.res_taken = 1; bi.res_target = mq[0].tgt;
      end
      #1;
      model_eval();
      if (!reset) begin
        checks++; if (bi.next_pc !== e_next || bi.full !== e_full || bi.flush !== e_flush || bi.btb_write !== e_bw) begin errors++; $display("FAIL rand n=%0d next/full/flush/bw got %h %b %b %b expected %h %b %b %b", n, bi.next_pc, bi.full, bi.flush, bi.btb_write, e_next, e_full, e_flush, e_bw); end
        checks++; if (bi.index_fetch !== bi.pc[3:0] || bi.tag_fetch !== bi.pc[15:4]) begin errors++; $display("FAIL rand_fetch_idx n=%0d got %h %h expected %h %h", n, bi.index_fetch, bi.tag_fetch, bi.pc[3:0], bi.pc[15:4]); end
        if (e_bw) begin
          checks++; if (bi.index_mem !== mq[0].pc[3:0] || bi.tag_mem !== mq[0].pc[15:4] || bi.btb_wtarget !== bi.res_target || bi.btb_wuc !== bi.res_uc) begin errors++; $display("FAIL rand_btbw n=%0d got %h %h %h %b expected %h %h %h %b", n, bi.index_mem, bi.tag_mem, bi.btb_wtarget, bi.btb_wuc, mq[0].pc[3:0], mq[0].pc[15:4], bi.res_target, bi.res_uc); end
        end
      end
      cycle();
    end
    reset = 0;
  endtask
  initial begin
    idle();
    bi.pc = 16'h0;
    test_reset();
    test_taken_miss();
    test_not_taken();
    test_saturate();
    test_uncond();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
